// File: rtl/irq_injector_if.sv
// Interrupt front-end bus: request lines, fetch/decoder handshake and
// the status/acknowledge outputs of the injector.
interface irq_injector_if #(
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] irq_mask;
    logic             ie;
    logic             fetch_valid;
    logic [15:0]      mem_instruction;
    logic [15:0]      instruction;
    logic             inject;
    logic             rti_done;
    logic [N_IRQ-1:0] irq_ack;
    logic             busy;
    logic             wake;

    // Driving side: interrupt sources, fetch stage, memory and decoder
    modport master (
        output irq, irq_mask, ie, fetch_valid, mem_instruction, rti_done,
        input  instruction, inject, irq_ack, busy, wake
    );

    // Injector side
    modport slave (
        input  irq, irq_mask, ie, fetch_valid, mem_instruction, rti_done,
        output instruction, inject, irq_ack, busy, wake
    );
endinterface

// File: rtl/irq_injector.sv
// Interrupt injector: latches rising edges on the request lines, picks the
// lowest-index unmasked pending line and, on the next instruction fetch,
// replaces the memory word with an 'int' instruction carrying the vector.
// Further injection is blocked until the decoder reports rti.
module irq_injector #(
    parameter int         N_IRQ    = 8,
    parameter logic [8:0] VEC_BASE = 9'd16
) (
    input logic           clk,
    input logic           rst_n,
    irq_injector_if.slave bus
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    // Reject line counts and vector bases that would not fit the 9-bit vector
    generate
        if (N_IRQ < 1 || N_IRQ > 16) begin : g_bad_n_irq
            $error("irq_injector: N_IRQ must be in 1..16");
        end
        if (int'(VEC_BASE) + N_IRQ - 1 > 511) begin : g_bad_vec_base
            $error("irq_injector: VEC_BASE + N_IRQ - 1 exceeds 511");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        INSERVICE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] edges;
    logic [N_IRQ-1:0] clear_mask;
    logic [N_IRQ-1:0] irq_ack_q;
    logic [8:0]       vec;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_found;
    logic             arm;
    logic             take;
    logic             wake_q;

    assign edges = bus.irq & ~irq_prev;

    // Priority pick: scanning from the top down leaves the lowest unmasked index
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && !bus.irq_mask[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state logic; a dropped enable in ARMED wins over a coincident fetch
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ie && cand_found) begin
                    arm        = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!bus.ie) begin
                    state_next = IDLE;
                end else if (bus.fetch_valid) begin
                    take       = 1'b1;
                    state_next = INSERVICE;
                end
            end
            INSERVICE: begin
                if (bus.rti_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign clear_mask = take ? (N_IRQ'(1) << sel) : '0;

    // Edge capture, pending bookkeeping (a fresh edge beats the service clear),
    // vector latch on arming, one-cycle acknowledge and registered wake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev  <= '0;
            pending   <= '0;
            vec       <= '0;
            sel       <= '0;
            irq_ack_q <= '0;
            wake_q    <= 1'b0;
        end else begin
            irq_prev  <= bus.irq;
            pending   <= (pending & ~clear_mask) | edges;
            irq_ack_q <= clear_mask;
            wake_q    <= |(pending & ~bus.irq_mask);
            if (arm) begin
                vec <= VEC_BASE + {{(9 - IDX_W){1'b0}}, cand_idx};
                sel <= cand_idx;
            end
        end
    end

    assign bus.inject      = take;
    assign bus.instruction = take ? {3'b100, 4'b0000, vec} : bus.mem_instruction;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.busy        = (state == INSERVICE);
    assign bus.wake        = wake_q;

endmodule

// File: tb/tb_irq_injector.sv
// Self-checking bench for irq_injector: a table of reset-onward vectors,
// hand-written multi-cycle corner sequences, and a randomized run compared
// against a behavioural model of the interrupt rules.
module tb_irq_injector;

    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irq_injector_if #(.N_IRQ(N)) bus ();

    irq_injector #(.N_IRQ(N), .VEC_BASE(9'd16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before 400000");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [7:0]  irq;
        logic        ie;
        logic        fv;
        logic        rti;
        logic [15:0] inj_word;
        logic        exp_inject;
        logic [7:0]  exp_ack;
        logic        exp_busy;
        logic        exp_wake;
    } vec_t;

    vec_t tbl[15];

    // Drive one cycle of inputs just after the falling edge, then settle
    task automatic applyStimulus(input logic [7:0] irq, input logic [7:0] mask,
                                 input logic ie, input logic fv, input logic rti,
                                 input logic [15:0] mem);
        @(negedge clk);
        bus.irq             = irq;
        bus.irq_mask        = mask;
        bus.ie              = ie;
        bus.fetch_valid     = fv;
        bus.rti_done        = rti;
        bus.mem_instruction = mem;
        #1;
    endtask

    // Compare every output against the expected values
    task automatic checkOutput(input string name, input logic [15:0] e_instr,
                               input logic e_inject, input logic [7:0] e_ack,
                               input logic e_busy, input logic e_wake);
        checks++;
        if (bus.instruction !== e_instr || bus.inject !== e_inject ||
            bus.irq_ack !== e_ack || bus.busy !== e_busy || bus.wake !== e_wake) begin
            failures++;
            $display("[TB] FAIL %s: got instr=%h inject=%b ack=%h busy=%b wake=%b, expected instr=%h inject=%b ack=%h busy=%b wake=%b",
                     name, bus.instruction, bus.inject, bus.irq_ack, bus.busy, bus.wake,
                     e_instr, e_inject, e_ack, e_busy, e_wake);
        end
    endtask

    // One hand-written cycle: random memory word, injection expected when word != 0
    task automatic cyc(input logic [7:0] irq, input logic [7:0] mask, input logic ie,
                       input logic fv, input logic rti, input string name,
                       input logic [15:0] word, input logic [7:0] e_ack,
                       input logic e_busy, input logic e_wake);
        logic [15:0] mem;
        mem = 16'($urandom);
        applyStimulus(irq, mask, ie, fv, rti, mem);
        checkOutput(name, (word != 16'h0000) ? word : mem, word != 16'h0000, e_ack, e_busy, e_wake);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n               = 1'b0;
        bus.irq             = '0;
        bus.irq_mask        = '0;
        bus.ie              = 1'b0;
        bus.fetch_valid     = 1'b0;
        bus.rti_done        = 1'b0;
        bus.mem_instruction = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural model state for the randomized run
    bit mPend[N];
    bit mPrev[N];
    int mMode;   // 0 waiting, 1 vector chosen, 2 handler running
    int mVec;
    int mSel;
    int mAck;
    bit mWake;

    initial begin
        logic [7:0]  rIrq;
        logic [7:0]  rMask;
        logic        rIe;
        logic        rFv;
        logic        rRti;
        logic [15:0] rMem;
        logic        eInj;
        logic [15:0] eInstr;
        logic [7:0]  eAck;
        int          cand;
        bit          anyUnmasked;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;

        // ---- reset values, checked while reset is held ----
        doReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_instruction = 16'hBEEF;
        bus.fetch_valid     = 1'b1;
        #1;
        checkOutput("reset_state", 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.fetch_valid = 1'b0;

        // ---- table: single request on line 2, then lines 5 and 1 together ----
        tbl[0]  = '{8'h04, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'h04, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h04, 1'b1, 1'b1, 1'b0, 16'h8012, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{8'h04, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h04, 1'b1, 1'b1};
        tbl[4]  = '{8'h00, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[5]  = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h8011, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h02, 1'b1, 1'b1};
        tbl[9]  = '{8'h22, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[10] = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[11] = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h8015, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[12] = '{8'h22, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h20, 1'b1, 1'b1};
        tbl[13] = '{8'h00, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0};
        for (int k = 0; k < 15; k++) begin
            logic [15:0] mem;
            mem = 16'hC000 | 16'(k);
            applyStimulus(tbl[k].irq, 8'h00, tbl[k].ie, tbl[k].fv, tbl[k].rti, mem);
            checkOutput($sformatf("table_row%0d", k), tbl[k].exp_inject ? tbl[k].inj_word : mem,
                        tbl[k].exp_inject, tbl[k].exp_ack, tbl[k].exp_busy, tbl[k].exp_wake);
        end

        // ---- masking holds the request and keeps wake low ----
        cyc(8'h08, 8'h08, 1, 1, 0, "mask_0", 16'h0000, 8'h00, 0, 0);
        cyc(8'h08, 8'h08, 1, 1, 0, "mask_1", 16'h0000, 8'h00, 0, 0);
        cyc(8'h08, 8'h08, 1, 1, 0, "mask_2", 16'h0000, 8'h00, 0, 0);
        cyc(8'h08, 8'h00, 1, 1, 0, "unmask", 16'h0000, 8'h00, 0, 0);
        cyc(8'h08, 8'h00, 1, 1, 0, "unmask_inj", 16'h8013, 8'h00, 0, 1);
        cyc(8'h08, 8'h00, 1, 1, 0, "unmask_ack", 16'h0000, 8'h08, 1, 1);
        cyc(8'h00, 8'h00, 1, 1, 1, "unmask_rti", 16'h0000, 8'h00, 1, 0);

        // ---- enable drop while armed ----
        cyc(8'h01, 8'h00, 1, 0, 0, "iedrop_edge", 16'h0000, 8'h00, 0, 0);
        cyc(8'h01, 8'h00, 1, 0, 0, "iedrop_arm", 16'h0000, 8'h00, 0, 0);
        cyc(8'h01, 8'h00, 1, 0, 0, "iedrop_wait", 16'h0000, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 0, 1, 0, "iedrop_fetch", 16'h0000, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 0, 1, 0, "iedrop_idle", 16'h0000, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 1, 1, 0, "iedrop_rearm", 16'h0000, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 1, 1, 0, "iedrop_inj", 16'h8010, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 1, 1, 0, "iedrop_ack", 16'h0000, 8'h01, 1, 1);

        // ---- no nesting in service, rti ignored while armed, stray rti in idle ----
        cyc(8'h00, 8'h00, 1, 1, 0, "nest_low", 16'h0000, 8'h00, 1, 0);
        cyc(8'h01, 8'h00, 1, 1, 0, "nest_edge", 16'h0000, 8'h00, 1, 0);
        cyc(8'h01, 8'h00, 1, 1, 0, "nest_block0", 16'h0000, 8'h00, 1, 0);
        cyc(8'h01, 8'h00, 1, 1, 0, "nest_block1", 16'h0000, 8'h00, 1, 1);
        cyc(8'h01, 8'h00, 1, 1, 1, "nest_rti", 16'h0000, 8'h00, 1, 1);
        cyc(8'h01, 8'h00, 1, 1, 0, "nest_idle", 16'h0000, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 1, 1, 1, "armed_rti_ign", 16'h8010, 8'h00, 0, 1);
        cyc(8'h01, 8'h00, 1, 1, 0, "nest_ack", 16'h0000, 8'h01, 1, 1);
        cyc(8'h00, 8'h00, 1, 1, 1, "nest_done", 16'h0000, 8'h00, 1, 0);
        cyc(8'h00, 8'h00, 1, 1, 1, "stray_rti", 16'h0000, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 1, 1, 0, "stray_after", 16'h0000, 8'h00, 0, 0);

        // ---- asynchronous reset while armed ----
        cyc(8'h04, 8'h00, 1, 0, 0, "rst_pre0", 16'h0000, 8'h00, 0, 0);
        cyc(8'h04, 8'h00, 1, 0, 0, "rst_pre1", 16'h0000, 8'h00, 0, 0);
        applyStimulus(8'h04, 8'h00, 1, 1, 0, 16'h3C3C);
        checkOutput("rst_armed", 16'h8012, 1'b1, 8'h00, 1'b0, 1'b1);
        #1;
        rst_n   = 1'b0;
        bus.irq = 8'h00;
        #1;
        checkOutput("rst_async", 16'h3C3C, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h00, 8'h00, 1, 1, 0, "rst_noack0", 16'h0000, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 1, 1, 0, "rst_noack1", 16'h0000, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 1, 1, 0, "rst_noack2", 16'h0000, 8'h00, 0, 0);

        // ---- randomized run against the behavioural model ----
        doReset();
        for (int i = 0; i < N; i++) begin
            mPend[i] = 1'b0;
            mPrev[i] = 1'b0;
        end
        mMode = 0;
        mVec  = 0;
        mSel  = 0;
        mAck  = -1;
        mWake = 1'b0;
        rIrq  = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rIrq[i] = ~rIrq[i];
                rMask[i] = ($urandom_range(0, 5) == 0);
            end
            rIe  = ($urandom_range(0, 9) != 0);
            rFv  = ($urandom_range(0, 1) == 1);
            rRti = ($urandom_range(0, 11) == 0);
            rMem = 16'($urandom);
            applyStimulus(rIrq, rMask, rIe, rFv, rRti, rMem);

            eInj   = (mMode == 1) && rIe && rFv;
            eInstr = eInj ? (16'h8000 | 16'(mVec)) : rMem;
            eAck   = (mAck >= 0) ? 8'(1 << mAck) : 8'h00;
            checkOutput($sformatf("random_c%0d", c), eInstr, eInj, eAck, mMode == 2, mWake);

            @(posedge clk);
            cand        = -1;
            anyUnmasked = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (mPend[i] && !rMask[i]) begin
                    anyUnmasked = 1'b1;
                    if (cand < 0) cand = i;
                end
            end
            mWake = anyUnmasked;
            mAck  = eInj ? mSel : -1;
            for (int i = 0; i < N; i++) begin
                if (eInj && i == mSel) mPend[i] = 1'b0;
                if (rIrq[i] && !mPrev[i]) mPend[i] = 1'b1;
                mPrev[i] = rIrq[i];
            end
            if (mMode == 0) begin
                if (rIe && cand >= 0) begin
                    mMode = 1;
                    mVec  = 16 + cand;
                    mSel  = cand;
                end
            end else if (mMode == 1) begin
                if (!rIe) mMode = 0;
                else if (rFv) mMode = 2;
            end else if (rRti) begin
                mMode = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_injector.md
# irq_injector

Interrupt front end for the CPU core. It latches external interrupt requests and picks the highest-priority unmasked one. On the next instruction fetch it substitutes a synthesized `int` instruction word for the memory word, so the instruction decoder then runs the normal interrupt vector sequence. The block sits between instruction memory and the decoder and blocks further injection until the decoder reports `rti`.

## Interface
Parameters:
- `N_IRQ`, 8, number of request lines (1..16)
- `VEC_BASE`, 9'd16, vector number of line 0; line i uses `VEC_BASE + i`; `VEC_BASE + N_IRQ - 1` must be ≤ 511

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `irq`  in  N_IRQ  request lines, rising-edge sensitive
- `irq_mask`  in  N_IRQ  1 = line masked (pending kept, not serviced)
- `ie`  in  1  global interrupt enable (PS I-bit)
- `fetch_valid`  in  1  fetch stage consumes an instruction word this cycle
- `mem_instruction`  in  16  word from instruction memory
- `instruction`  out  16  word to decoder
- `inject`  out  1  `instruction` is synthesized this cycle
- `rti_done`  in  1  one-cycle strobe from decoder `rti`
- `irq_ack`  out  N_IRQ  one-hot, one-cycle acknowledge
- `busy`  out  1  an interrupt is in service
- `wake`  out  1  unmasked request pending; releases `halt`/`wait`

## Operation
- Edge detect: `irq_prev` register. An edge on line i is `irq[i] & ~irq_prev[i]`; it sets `pending[i]`.
- Candidate: lowest index i with `pending[i] & ~irq_mask[i]`. Index 0 has the highest priority.
- Synthesized word: `{3'b100, 4'b0000, vec[8:0]}`. This is inst_type 4 with bits 12:9 zero, so the decoder asserts `_int` and reads imm9 = vector.
- FSM states IDLE, ARMED, INSERVICE:
  - IDLE → ARMED when `ie` and a candidate exists. Latch `vec = VEC_BASE + i` and `sel = i`.
  - ARMED → IDLE if `ie` drops before the fetch. Nothing is injected and pending is kept.
  - ARMED → INSERVICE on `fetch_valid`. In that cycle `instruction` is the synthesized word and `inject` is 1.
  - INSERVICE → IDLE on `rti_done`.
  - `rti_done` in IDLE or ARMED is ignored.
- The latched vector is not re-evaluated in ARMED; a higher-priority edge arriving then waits for the next round.
- No nesting: candidates are not taken while in INSERVICE.
- Acknowledge: on the edge that leaves ARMED via fetch, `pending[sel]` clears. `irq_ack[sel]` is 1 for the following cycle only.
- A new edge on `sel` in the same cycle as the clear sets the bit again (set wins).
- Outside the inject cycle, `instruction = mem_instruction` combinationally and `inject = 0`.
- `busy` = (state == INSERVICE).
- `wake` is registered: `|(pending & ~irq_mask)`, independent of `ie` and state.
- Arithmetic: vector add is 9-bit; parameter legality is checked at elaboration and the vector never wraps.

## Timing
- Reset (async, `rst_n` = 0): state IDLE, `pending` = 0, `irq_prev` = 0, `vec` = 0, `sel` = 0, `irq_ack` = 0, `wake` = 0, `busy` = 0, `inject` = 0, `instruction` = `mem_instruction`.
- A line already high at reset release counts as an edge on the first clock.
- Latency with `ie` = 1, unmasked, state IDLE:
  - edge sampled at edge 0 → pending set after edge 0;
  - ARMED after edge 1; `wake` = 1 after edge 1;
  - injection in the first cycle after edge 1 with `fetch_valid` = 1.
- Inject and ack: `inject` is combinational in the fetch cycle; `irq_ack` follows exactly one cycle later.
- `rti_done` and a new candidate in the same cycle: go to IDLE. ARMED is reached one cycle later.
- Reset asserted in ARMED or INSERVICE: returns to IDLE immediately with all pending lost; no ack is issued.

## Test plan
- Single request: `ie` = 1, line 2 rises, `fetch_valid` held 1 → at the fetch, `instruction` = 16'h8012 and `inject` = 1. The following cycle `irq_ack` = 8'h04, then `busy` = 1.
- Priority: lines 5 and 1 rise on the same edge → line 1 is injected first (16'h8011). After `rti_done`, line 5 is injected (16'h8015).
- Masking and wake: `irq_mask[3]` = 1, line 3 rises → no injection and `wake` = 0. Clear the mask → `wake` = 1 and line 3 is injected (16'h8013).
- Enable drop: reach ARMED, then `ie` = 0 before `fetch_valid` → back to IDLE with `instruction` = `mem_instruction`. Restore `ie` → line is injected.
- No nesting and ignored rti: line 0 rises while in INSERVICE → no injection. A stray `rti_done` in IDLE has no effect. After the real `rti_done`, 16'h8010 is injected.
- Async reset mid-ARMED: pulse `rst_n` low between clocks → all outputs at reset values immediately; no `irq_ack` pulse follows.
